// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module : dmem_responder_pkg
// Desc   : Shared FSM encoding, default widths and address range helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 8;
  localparam int PROC_ADDR_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_HOST_ACC = 2'd1;
  localparam state_t ST_HOST_ACK = 2'd2;

  // An address is implemented when every bit above the word-address field is zero.
  function automatic logic addr_in_range(input logic [PROC_ADDR_W-1:0] addr,
                                         input int unsigned addr_w);
    return (addr >> addr_w) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module : dmem_responder_if
// Desc   : Processor data-memory bus plus host load/dump port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              read;
  logic              write;
  logic [15:0]       arout;
  logic [DATA_W-1:0] acout;
  logic [DATA_W-1:0] dram;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_ack;
  logic              range_err;
  logic [15:0]       acc_cnt;

  modport slave (
    input  read, write, arout, acout,
    input  host_req, host_we, host_addr, host_wdata,
    output dram, host_rdata, host_ack, range_err, acc_cnt
  );

  modport master (
    output read, write, arout, acout,
    output host_req, host_we, host_addr, host_wdata,
    input  dram, host_rdata, host_ack, range_err, acc_cnt
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder_array.sv
// ============================================================================
// Module : dmem_array
// Desc   : Single-port synchronous RAM with registered read data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module : dmem_responder
// Desc   : Data-memory responder with processor-priority host load/dump port.
//          Optional access counter enabled by macro DMEM_ACC_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] host_addr_q, host_addr_d;
  logic              host_we_q, host_we_d;
  logic [DATA_W-1:0] host_wdata_q, host_wdata_d;
  logic              proc_rd_q, proc_rd_d;
  logic              host_rd_q, host_rd_d;
  logic [DATA_W-1:0] dram_q, dram_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              range_err_q, range_err_d;

  logic              proc_act;
  logic              proc_in_range;
  logic              proc_wr_ok;
  logic              proc_rd_ok;
  logic              host_latch;
  logic              host_go;
  logic              host_ack;
  logic [DATA_W-1:0] dram_now;
  logic [DATA_W-1:0] host_rdata_now;

  logic              arr_en;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign proc_act      = bus.read | bus.write;
  assign proc_in_range = addr_in_range(bus.arout, ADDR_W);
  assign proc_wr_ok    = bus.write & proc_in_range;
  assign proc_rd_ok    = bus.read & ~bus.write & proc_in_range;
  assign host_latch    = (state_q == ST_IDLE) & bus.host_req & ~proc_act;
  assign host_go       = (state_q == ST_HOST_ACC) & ~proc_act;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (host_latch) state_d = ST_HOST_ACC;
      ST_HOST_ACC: if (host_go)    state_d = ST_HOST_ACK;
      ST_HOST_ACK:                 state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    host_ack = (state_q == ST_HOST_ACK);
  end

  // The processor always owns the array when it strobes; the host only fills gaps.
  always_comb begin
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = bus.arout[ADDR_W-1:0];
    arr_wdata = bus.acout;
    if (proc_act) begin
      arr_en = proc_wr_ok | proc_rd_ok;
      arr_we = proc_wr_ok;
    end else if (host_go) begin
      arr_en    = 1'b1;
      arr_we    = host_we_q;
      arr_addr  = host_addr_q;
      arr_wdata = host_wdata_q;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Array read data is steered to whichever requester read last cycle; the
  // other output keeps its held copy.
  assign dram_now       = proc_rd_q ? arr_rdata : dram_q;
  assign host_rdata_now = host_rd_q ? arr_rdata : host_rdata_q;

  always_comb begin
    host_addr_d  = host_addr_q;
    host_we_d    = host_we_q;
    host_wdata_d = host_wdata_q;
    if (host_latch) begin
      host_addr_d  = bus.host_addr;
      host_we_d    = bus.host_we;
      host_wdata_d = bus.host_wdata;
    end
    proc_rd_d    = proc_rd_ok;
    host_rd_d    = host_go & ~host_we_q;
    dram_d       = (bus.read & ~bus.write & ~proc_in_range) ? '0 : dram_now;
    host_rdata_d = host_rdata_now;
    range_err_d  = range_err_q |
                   (proc_act & (~proc_in_range | (bus.read & bus.write)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_addr_q  <= '0;
      host_we_q    <= 1'b0;
      host_wdata_q <= '0;
      proc_rd_q    <= 1'b0;
      host_rd_q    <= 1'b0;
      dram_q       <= '0;
      host_rdata_q <= '0;
      range_err_q  <= 1'b0;
    end else begin
      host_addr_q  <= host_addr_d;
      host_we_q    <= host_we_d;
      host_wdata_q <= host_wdata_d;
      proc_rd_q    <= proc_rd_d;
      host_rd_q    <= host_rd_d;
      dram_q       <= dram_d;
      host_rdata_q <= host_rdata_d;
      range_err_q  <= range_err_d;
    end
  end

  assign bus.dram       = dram_now;
  assign bus.host_rdata = host_rdata_now;
  assign bus.host_ack   = host_ack;
  assign bus.range_err  = range_err_q;

`ifdef DMEM_ACC_CNT_EN
  logic [15:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (proc_act && (acc_cnt_q != 16'hFFFF)) begin
      acc_cnt_d = acc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign bus.acc_cnt = acc_cnt_q;
`else
  assign bus.acc_cnt = '0;
`endif

endmodule

`default_nettype wire
